// File: rtl/frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_pkg
//  Description : Shared definitions for the serial frame deserializer.
//                - frame_state_t : receive FSM states
//                - START_BIT     : line level of a start bit
//                - STOP_BIT      : line level of a valid stop bit
//  Revision    : 1.0  initial release
// ============================================================================
package frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage : frame_pkg
`default_nettype wire

// File: rtl/serial_frame_deser.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_deser
//  Description : Deserializes a strobed serial stream framed as
//                start(0), DATA_W data bits LSB-first, optional even parity,
//                stop(1). Each good word is offered through a one-entry
//                valid/ready output register; framing and overrun errors are
//                reported as one-cycle registered pulses.
//  Ports       : clk        - clock, all logic on posedge
//                rstn       - synchronous active-low reset
//                bit_in     - serial bit (registered upstream)
//                bit_en     - sample strobe; bit_in consumed only when 1
//                out_data   - received word
//                out_perr   - parity mismatch flag for out_data
//                out_valid  - output slot holds a word
//                out_ready  - consumer accepts when out_valid && out_ready
//                frame_err  - pulse: stop bit sampled low
//                overrun    - pulse: good word dropped, slot was full
//  Revision    : 1.0  initial release
// ============================================================================
module serial_frame_deser
    import frame_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              bit_in,
    input  logic              bit_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_perr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              overrun
);

    localparam int              CNT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic            c_PAR_ON   = (PARITY_EN != 0);

    // ------------------------------------------------------------------
    // State and datapath registers with their next-state values
    // ------------------------------------------------------------------
    frame_state_t      r_state;
    frame_state_t      w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              r_perr_q;
    logic              w_perr_q_nxt;

    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] w_out_data_nxt;
    logic              r_out_perr;
    logic              w_out_perr_nxt;
    logic              r_out_valid;
    logic              w_out_valid_nxt;
    logic              r_frame_err;
    logic              w_frame_err_nxt;
    logic              r_overrun;
    logic              w_overrun_nxt;

    logic              w_slot_free;
    logic              w_load;

    // The slot can take a new word if it is empty, or if the consumer is
    // draining it in this very cycle.
    assign w_slot_free = !r_out_valid || out_ready;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_shift_nxt     = r_shift;
        w_perr_q_nxt    = r_perr_q;
        w_load          = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_overrun_nxt   = 1'b0;

        if (bit_en) begin
            unique case (r_state)
                IDLE: begin
                    if (bit_in == START_BIT) begin
                        w_state_nxt = DATA;
                        w_cnt_nxt   = '0;
                    end
                end

                DATA: begin
                    w_shift_nxt[r_cnt] = bit_in;
                    if (r_cnt == c_CNT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_PAR_ON ? PARITY : STOP;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end

                PARITY: begin
                    // Even parity: data ones plus the parity bit must be even.
                    w_perr_q_nxt = c_PAR_ON & ((^r_shift) ^ bit_in);
                    w_state_nxt  = STOP;
                end

                STOP: begin
                    // A low stop bit is a framing error; it is not re-used
                    // as the start of the next frame.
                    w_state_nxt = IDLE;
                    if (bit_in == STOP_BIT) begin
                        if (w_slot_free) begin
                            w_load        = 1'b1;
                        end else begin
                            w_overrun_nxt = 1'b1;
                        end
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
                end

                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end

        // Output slot: a load wins over a simultaneous accept, keeping
        // valid high with the new word.
        w_out_data_nxt  = r_out_data;
        w_out_perr_nxt  = r_out_perr;
        w_out_valid_nxt = r_out_valid;
        if (w_load) begin
            w_out_data_nxt  = r_shift;
            w_out_perr_nxt  = c_PAR_ON & r_perr_q;
            w_out_valid_nxt = 1'b1;
        end else if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_perr_q    <= 1'b0;
            r_out_data  <= '0;
            r_out_perr  <= 1'b0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_perr_q    <= w_perr_q_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_perr  <= w_out_perr_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    assign out_data  = r_out_data;
    assign out_perr  = r_out_perr;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule : serial_frame_deser
`default_nettype wire

// File: tb/tb_serial_frame_deser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_frame_deser
//  Description : Self-checking bench for serial_frame_deser (DATA_W=8,
//                PARITY_EN=1). A word-level model tracks the output slot and
//                the error pulses expected from each transmitted frame.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_frame_deser;

    logic       clk;
    logic       rstn;
    logic       bit_in;
    logic       bit_en;
    logic [7:0] out_data;
    logic       out_perr;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic       overrun;

    int vectors;
    int miscompares;

    // Word-level model of the output slot
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_perr;

    bit gaps_en;

    serial_frame_deser #(
        .DATA_W    (8),
        .PARITY_EN (1)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bit_in    (bit_in),
        .bit_en    (bit_en),
        .out_data  (out_data),
        .out_perr  (out_perr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock. stop_evt marks the strobe carrying a stop bit; w/pe are the
    // word and parity-error flag that frame would deliver.
    task automatic tick(input logic en, input logic b, input logic rdy,
                        input bit stop_evt, input logic [7:0] w, input logic pe,
                        input string tag);
        logic acc;
        logic e_ferr;
        logic e_ovr;
        acc    = m_valid && rdy;
        e_ferr = 1'b0;
        e_ovr  = 1'b0;
        if (stop_evt && en) begin
            if (b == 1'b0) begin
                e_ferr = 1'b1;
            end else if (!m_valid || rdy) begin
                m_valid = 1'b1;
                m_data  = w;
                m_perr  = pe;
                acc     = 1'b0;
            end else begin
                e_ovr = 1'b1;
            end
        end
        if (acc) m_valid = 1'b0;

        bit_en    = en;
        bit_in    = b;
        out_ready = rdy;
        @(posedge clk);
        #1;
        bit_en = 1'b0;

        vectors++;
        if (out_valid !== m_valid) begin
            miscompares++;
            $display("FAIL %s out_valid: got %b expected %b", tag, out_valid, m_valid);
        end
        if (frame_err !== e_ferr) begin
            miscompares++;
            $display("FAIL %s frame_err: got %b expected %b", tag, frame_err, e_ferr);
        end
        if (overrun !== e_ovr) begin
            miscompares++;
            $display("FAIL %s overrun: got %b expected %b", tag, overrun, e_ovr);
        end
        if (m_valid && (out_data !== m_data)) begin
            miscompares++;
            $display("FAIL %s out_data: got %h expected %h", tag, out_data, m_data);
        end
        if (m_valid && (out_perr !== m_perr)) begin
            miscompares++;
            $display("FAIL %s out_perr: got %b expected %b", tag, out_perr, m_perr);
        end
    endtask

    // ready_mode: 0 all low, 1 all high, 2 low except the stop strobe, 3 random
    function automatic logic pick_ready(input int mode, input bit at_stop);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return at_stop;
            default: return logic'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic gap(input int mode, input string tag);
        if (gaps_en) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                tick(1'b0, logic'($urandom_range(0, 1)), pick_ready(mode, 1'b0),
                     1'b0, 8'h00, 1'b0, tag);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int mode, input string tag);
        logic pe;
        pe = (^d) ^ par;
        tick(1'b1, 1'b1, pick_ready(mode, 1'b0), 1'b0, 8'h00, 1'b0, tag);  // idle
        gap(mode, tag);
        tick(1'b1, 1'b0, pick_ready(mode, 1'b0), 1'b0, 8'h00, 1'b0, tag);  // start
        for (int i = 0; i < 8; i++) begin
            gap(mode, tag);
            tick(1'b1, d[i], pick_ready(mode, 1'b0), 1'b0, 8'h00, 1'b0, tag);
        end
        gap(mode, tag);
        tick(1'b1, par, pick_ready(mode, 1'b0), 1'b0, 8'h00, 1'b0, tag);
        gap(mode, tag);
        tick(1'b1, stp, pick_ready(mode, 1'b1), 1'b1, d, pe, tag);
    endtask

    task automatic drain();
        tick(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, "drain");
    endtask

    task automatic do_reset(input string tag);
        rstn      = 1'b0;
        bit_en    = 1'b1;
        bit_in    = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rstn    = 1'b1;
        bit_en  = 1'b0;
        m_valid = 1'b0;
        vectors++;
        if ({out_valid, out_data, out_perr, frame_err, overrun} !== 12'h000) begin
            miscompares++;
            $display("FAIL %s outputs: got v=%b d=%h p=%b fe=%b ov=%b expected all 0",
                     tag, out_valid, out_data, out_perr, frame_err, overrun);
        end
    endtask

    task automatic test_reset();
        do_reset("reset");
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "idle");
    endtask

    task automatic test_good_frame();
        send_frame(8'hA5, 1'b0, 1'b1, 0, "good_A5");
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "hold_A5");
        drain();
    endtask

    task automatic test_parity_err();
        send_frame(8'hA5, 1'b1, 1'b1, 0, "perr_A5");
        drain();
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0, 1'b0, 0, "ferr_3C");
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "ferr_after");
        send_frame(8'h96, 1'b0, 1'b1, 0, "after_ferr");
        drain();
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b0, 1'b1, 0, "ovr_11");
        send_frame(8'h22, 1'b0, 1'b1, 0, "ovr_22");
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "ovr_hold");
        drain();
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b0, 1'b1, 0, "b2b_11");
        send_frame(8'h22, 1'b0, 1'b1, 2, "b2b_22");
        drain();
    endtask

    task automatic test_midframe_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "mid_start");
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "mid_bits");
        do_reset("mid_reset");
        send_frame(8'h5A, 1'b0, 1'b1, 0, "post_reset_5A");
        drain();
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       par;
        logic       stp;
        gaps_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            d   = 8'($urandom);
            par = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
            stp = ($urandom_range(0, 7) != 0);
            send_frame(d, par, stp, 3, "random");
        end
        gaps_en = 1'b0;
        drain();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_valid     = 1'b0;
        m_data      = 8'h00;
        m_perr      = 1'b0;
        gaps_en     = 1'b0;
        rstn        = 1'b0;
        bit_en      = 1'b0;
        bit_in      = 1'b1;
        out_ready   = 1'b0;
        @(posedge clk);
        #1;

        test_reset();
        test_good_frame();
        test_parity_err();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_midframe_reset();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_serial_frame_deser
`default_nettype wire
